// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Round-robin scheduler sharing one UART transmitter among
//               NREQ byte producers. Issues a one-cycle tx_start, waits for
//               tx_done (bounded by a watchdog) and acknowledges the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = 18,
    parameter int ID_W           = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ack,
    output logic              req_err,
    output logic [ID_W-1:0]   grant_id,
    output logic              busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done
);

    localparam logic [1:0]      c_st_idle    = 2'd0;
    localparam logic [1:0]      c_st_start   = 2'd1;
    localparam logic [1:0]      c_st_wait    = 2'd2;
    localparam logic [1:0]      c_st_release = 2'd3;

    localparam logic [ID_W:0]   c_nreq_ext   = (ID_W+1)'(NREQ);
    localparam logic [ID_W-1:0] c_last_id    = ID_W'(NREQ-1);
    localparam logic [CNT_W-1:0] c_wdog_last = CNT_W'(TIMEOUT_CYCLES-1);

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_grant;
    logic [7:0]       r_data;
    logic             r_start;
    logic [NREQ-1:0]  r_ack;
    logic             r_err;
    logic             r_busy;
    logic [CNT_W-1:0] r_wdog;

    logic [7:0]       w_bytes [NREQ];
    logic             w_any;
    logic [ID_W-1:0]  w_win;
    logic [NREQ-1:0]  w_grant_onehot;
    logic [ID_W-1:0]  w_ptr_next;

    // Split the flat request bus into one byte per requester
    generate
        for (genvar k = 0; k < NREQ; k++) begin : g_bytes
            assign w_bytes[k] = req_data[8*k +: 8];
        end
    endgenerate

    // Round-robin pick: walk offsets from the highest down so the lowest
    // offset above ptr (modulo NREQ) is the one left standing
    always_comb begin : p_arb
        logic [ID_W:0] v_sum;
        v_sum = '0;
        w_any = 1'b0;
        w_win = r_ptr;
        for (int i = NREQ-1; i >= 0; i--) begin
            v_sum = {1'b0, r_ptr} + (ID_W+1)'(i);
            if (v_sum >= c_nreq_ext) begin
                v_sum = v_sum - c_nreq_ext;
            end
            if (req_valid[v_sum[ID_W-1:0]]) begin
                w_any = 1'b1;
                w_win = v_sum[ID_W-1:0];
            end
        end
    end

    assign w_grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
    assign w_ptr_next     = (r_grant == c_last_id) ? '0 : r_grant + 1'b1;

    // Scheduler FSM with all outputs registered; ack/err are raised on the
    // transition into RELEASE so they are valid for exactly that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_ptr   <= '0;
            r_grant <= '0;
            r_data  <= 8'h00;
            r_start <= 1'b0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_wdog  <= '0;
        end else begin
            r_start <= 1'b0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_data  <= w_bytes[w_win];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= c_st_start;
                    end
                end
                c_st_start: begin
                    r_wdog  <= '0;
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    r_wdog <= r_wdog + 1'b1;
                    // Completion takes priority over a simultaneous timeout
                    if (tx_done) begin
                        r_ack   <= w_grant_onehot;
                        r_state <= c_st_release;
                    end else if (r_wdog == c_wdog_last) begin
                        r_ack   <= w_grant_onehot;
                        r_err   <= 1'b1;
                        r_state <= c_st_release;
                    end
                end
                c_st_release: begin
                    r_ptr   <= w_ptr_next;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign req_ack  = r_ack;
    assign req_err  = r_err;
    assign grant_id = r_grant;
    assign busy     = r_busy;
    assign tx_start = r_start;
    assign tx_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Self-checking bench for uart_tx_sched. Expected grants come
//               from a round-robin pick function; expected ack timing and
//               error flag come from the tx_done delay by plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ack;
    logic        req_err;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int m_ptr = 0;

    uart_tx_sched #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .grant_id  (grant_id),
        .busy      (busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First requester at or after ptr, wrapping modulo NREQ
    function automatic int rr_pick(input int ptr, input logic [3:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    // One complete transfer, entered and left in an IDLE cycle.
    // d = cycles from the tx_start cycle to the tx_done cycle; d > TMO means
    // no tx_done reaches WAIT, so the watchdog fires.
    task automatic xfer(input logic [3:0] valid, input logic [31:0] data,
                        input int d, input bit drop, input bit mid_drop,
                        output int w);
        int         ack_k;
        logic [7:0] exp_b;
        logic       exp_err;
        req_valid = valid;
        req_data  = data;
        w         = rr_pick(m_ptr, valid);
        exp_b     = data[8*w +: 8];
        ack_k     = (d <= TMO) ? d + 1 : TMO + 1;
        exp_err   = (d > TMO);
        tick();
        chk("start", tx_start, 1);
        chk("grant", grant_id, w);
        chk("tx_data", tx_data, exp_b);
        chk("busy_start", busy, 1);
        chk("ack_in_start", req_ack, 0);
        req_data = $urandom;
        if (mid_drop) req_valid[w] = 1'b0;
        for (int k = 1; k <= ack_k; k++) begin
            tick();
            chk("no_restart", tx_start, 0);
            chk("busy_wait", busy, 1);
            chk("data_hold", tx_data, exp_b);
            if (k < ack_k) begin
                chk("early_ack", req_ack, 0);
            end else begin
                chk("ack", req_ack, 32'd1 << w);
                chk("err", req_err, exp_err);
            end
            tx_done = (k == d) || ((k == ack_k) && ($urandom_range(0, 1) == 1));
        end
        if (drop) req_valid[w] = 1'b0;
        m_ptr = (w + 1) % NREQ;
        tick();
        tx_done = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_ack", req_ack, 0);
        chk("idle_err", req_err, 0);
        chk("idle_start", tx_start, 0);
        chk("idle_grant_hold", grant_id, w);
    endtask

    task automatic idle_run(input int n, input bit spurious);
        req_valid = '0;
        for (int i = 0; i < n; i++) begin
            tx_done = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            chk("idle_noack", req_ack, 0);
            chk("idle_nostart", tx_start, 0);
            chk("idle_notbusy", busy, 0);
        end
        tx_done = 1'b0;
    endtask

    initial begin
        int         w;
        logic [3:0] pend;

        // Reset values
        tick();
        tick();
        chk("rst_start", tx_start, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_err", req_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_data", tx_data, 0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 2
        xfer(4'b0100, 32'h00A5_0000, 6, 1'b1, 1'b0, w);
        idle_run(5, 1'b1);

        // Pointer fairness: serve 3, then 0 beats 3, then 3
        xfer(4'b1000, $urandom, 3, 1'b1, 1'b0, w);
        xfer(4'b1001, $urandom, 3, 1'b1, 1'b0, w);
        xfer(req_valid, $urandom, 3, 1'b1, 1'b0, w);

        // Continuous round robin over all four
        for (int i = 0; i < 8; i++) begin
            xfer(4'b1111, 32'h1312_1110, 5, 1'b0, 1'b0, w);
        end
        idle_run(2, 1'b0);

        // Watchdog expiry, then a normal transfer
        xfer(4'b0010, $urandom, TMO + 50, 1'b1, 1'b0, w);
        xfer(4'b0001, $urandom, 2, 1'b1, 1'b0, w);

        // tx_done on the last watchdog cycle still counts as success
        xfer(4'b0100, $urandom, TMO, 1'b1, 1'b0, w);
        idle_run(4, 1'b1);

        // Reset during WAIT: ptr left at 2 so a stale pointer would pick 3
        xfer(4'b0010, $urandom, 2, 1'b1, 1'b0, w);
        req_valid = 4'b0100;
        req_data  = $urandom;
        tick();
        chk("pre_rst_start", tx_start, 1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_grant", grant_id, 0);
        chk("arst_data", tx_data, 0);
        chk("arst_ack", req_ack, 0);
        chk("arst_start", tx_start, 0);
        m_ptr = 0;
        req_valid = 4'b1010;
        tick();
        chk("in_rst_ack", req_ack, 0);
        rst_n = 1'b1;
        xfer(4'b1010, $urandom, 4, 1'b1, 1'b0, w);
        idle_run(2, 1'b0);

        // Randomised traffic with data churn, mid-transfer drops and timeouts
        pend = '0;
        for (int i = 0; i < 40; i++) begin
            pend = pend | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if (pend == 4'b0000) pend = 4'($urandom_range(1, 15));
            xfer(pend, $urandom, $urandom_range(1, TMO + 2),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), w);
            pend = req_valid;
        end
        idle_run(3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
